// File: rtl/mips_multicycle_ctrl.sv
// Moore-style multicycle control FSM for the shared MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives every mux select and write enable.
module mips_multicycle_ctrl #(
    parameter int FETCH_WAIT = 0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT);

    logic [3:0] next_state;
    logic [3:0] wait_cnt;
    logic       fetch_hit;
    logic       funct_ok;
    logic       pcwrite, branch, valid_state;
    logic       memwrite_raw, irwrite_raw, regwrite_raw, done_raw, illegal_raw;
    logic [1:0] aluop;

    assign fetch_hit   = (wait_cnt == WAIT_LAST);
    assign valid_state = (state < 4'd12);
    assign funct_ok    = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                         (funct == 6'b100101) || (funct == 6'b101010);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && !fetch_hit) wait_cnt <= wait_cnt + 4'd1;
            else                                wait_cnt <= 4'd0;
        end
    end

    always_comb begin
        next_state   = S_FETCH;
        iord         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_raw = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        aluop        = 2'b00;
        done_raw     = 1'b0;
        illegal_raw  = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb = 2'b01;
                if (fetch_hit) begin
                    irwrite_raw = 1'b1;
                    pcwrite     = 1'b1;
                    next_state  = S_DECODE;
                end else begin
                    next_state  = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    OP_RTYPE: begin
                        if (funct_ok) next_state  = S_RTYPEEX;
                        else          illegal_raw = 1'b1;
                    end
                    default:      illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = 2'b10;
                next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsrc    = 2'b01;
                branch   = 1'b1;
                done_raw = 1'b1;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_JEX: begin
                pcsrc    = 2'b10;
                pcwrite  = 1'b1;
                done_raw = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Unused encodings drive every output low, including the ALU control.
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
        if (!valid_state) alucontrol = 3'b000;
    end

    // Reset suppresses every write and pulse so an abandoned instruction leaves no trace.
    assign memwrite   = memwrite_raw & ~reset;
    assign irwrite    = irwrite_raw  & ~reset;
    assign regwrite   = regwrite_raw & ~reset;
    assign pcen       = (pcwrite | (branch & zero)) & ~reset;
    assign instr_done = done_raw     & ~reset;
    assign illegal_op = illegal_raw  & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: table-driven cycle vectors on a FETCH_WAIT=0
// instance plus a hand-written back-to-back sw sequence on a FETCH_WAIT=2 instance.
module tb_mips_multicycle_ctrl;

    // Control vector layout: iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca _ alusrcb _ pcsrc _ pcen _ alucontrol _ instr_done,illegal_op
    localparam logic [16:0] C_F   = 17'b0010000_01_00_1_010_00;
    localparam logic [16:0] C_FW  = 17'b0000000_01_00_0_010_00;
    localparam logic [16:0] C_D   = 17'b0000000_11_00_0_010_00;
    localparam logic [16:0] C_DI  = 17'b0000000_11_00_0_010_01;
    localparam logic [16:0] C_MA  = 17'b0000001_10_00_0_010_00;
    localparam logic [16:0] C_MR  = 17'b1000000_00_00_0_010_00;
    localparam logic [16:0] C_MWB = 17'b0000110_00_00_0_010_10;
    localparam logic [16:0] C_MWR = 17'b1100000_00_00_0_010_10;
    localparam logic [16:0] C_RWB = 17'b0001010_00_00_0_010_10;
    localparam logic [16:0] C_BZ1 = 17'b0000001_00_01_1_110_10;
    localparam logic [16:0] C_BZ0 = 17'b0000001_00_01_0_110_10;
    localparam logic [16:0] C_AE  = 17'b0000001_10_00_0_010_00;
    localparam logic [16:0] C_AWB = 17'b0000010_00_00_0_010_10;
    localparam logic [16:0] C_J   = 17'b0000000_00_10_1_010_10;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  exp_state;
        logic [16:0] exp_ctrl;
    } vec_t;

    logic clk = 1'b0;
    logic reset, zero;
    logic [5:0] op, funct;

    logic       iord_a, memwrite_a, irwrite_a, regdst_a, memtoreg_a, regwrite_a, alusrca_a, pcen_a;
    logic       done_a, illegal_a;
    logic [1:0] alusrcb_a, pcsrc_a;
    logic [2:0] aluctl_a;
    logic [3:0] state_a;

    logic       iord_b, memwrite_b, irwrite_b, regdst_b, memtoreg_b, regwrite_b, alusrca_b, pcen_b;
    logic       done_b, illegal_b;
    logic [1:0] alusrcb_b, pcsrc_b;
    logic [2:0] aluctl_b;
    logic [3:0] state_b;

    logic [20:0] exp_q[$];
    vec_t        vecs[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.FETCH_WAIT(0)) dut_a (
        .CLOCK_50(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord_a), .memwrite(memwrite_a), .irwrite(irwrite_a), .regdst(regdst_a),
        .memtoreg(memtoreg_a), .regwrite(regwrite_a), .alusrca(alusrca_a), .alusrcb(alusrcb_a),
        .pcsrc(pcsrc_a), .pcen(pcen_a), .alucontrol(aluctl_a), .instr_done(done_a),
        .illegal_op(illegal_a), .state(state_a)
    );

    mips_multicycle_ctrl #(.FETCH_WAIT(2)) dut_b (
        .CLOCK_50(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord_b), .memwrite(memwrite_b), .irwrite(irwrite_b), .regdst(regdst_b),
        .memtoreg(memtoreg_b), .regwrite(regwrite_b), .alusrca(alusrca_b), .alusrcb(alusrcb_b),
        .pcsrc(pcsrc_b), .pcen(pcen_b), .alucontrol(aluctl_b), .instr_done(done_b),
        .illegal_op(illegal_b), .state(state_b)
    );

    function automatic logic [16:0] rex(input logic [2:0] alu);
        return {7'b0000001, 2'b00, 2'b00, 1'b0, alu, 2'b00};
    endfunction

    task automatic add(input string name, input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [3:0] st, input logic [16:0] ctrl);
        vec_t v;
        v.name = name; v.rst = rst; v.op = o; v.funct = f; v.zero = z;
        v.exp_state = st; v.exp_ctrl = ctrl;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [20:0] act);
        logic [20:0] exp;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got state=%0d ctrl=%b", name, act[20:17], act[16:0]);
            return;
        end
        exp = exp_q.pop_front();
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                     name, act[20:17], act[16:0], exp[20:17], exp[16:0]);
        end
    endtask

    function automatic logic [20:0] obs_a();
        return {state_a, iord_a, memwrite_a, irwrite_a, regdst_a, memtoreg_a, regwrite_a, alusrca_a,
                alusrcb_a, pcsrc_a, pcen_a, aluctl_a, done_a, illegal_a};
    endfunction

    function automatic logic [20:0] obs_b();
        return {state_b, iord_b, memwrite_b, irwrite_b, regdst_b, memtoreg_b, regwrite_b, alusrca_b,
                alusrcb_b, pcsrc_b, pcen_b, aluctl_b, done_b, illegal_b};
    endfunction

    initial begin
        // lw with zero held high: pcen must stay tied to pcwrite outside BEQEX
        add("lw.fetch",  0, LW, 6'd0, 1, 4'd0, C_F);
        add("lw.decode", 0, LW, 6'd0, 1, 4'd1, C_D);
        add("lw.memadr", 0, LW, 6'd0, 1, 4'd2, C_MA);
        add("lw.memrd",  0, LW, 6'd0, 1, 4'd3, C_MR);
        add("lw.memwb",  0, LW, 6'd0, 1, 4'd4, C_MWB);
        add("sw.fetch",  0, SW, 6'd0, 0, 4'd0, C_F);
        add("sw.decode", 0, SW, 6'd0, 0, 4'd1, C_D);
        add("sw.memadr", 0, SW, 6'd0, 0, 4'd2, C_MA);
        add("sw.memwr",  0, SW, 6'd0, 0, 4'd5, C_MWR);
        add("slt.fetch", 0, RT, 6'b101010, 0, 4'd0, C_F);
        add("slt.dec",   0, RT, 6'b101010, 0, 4'd1, C_D);
        add("slt.ex",    0, RT, 6'b101010, 0, 4'd6, rex(3'b111));
        add("slt.wb",    0, RT, 6'b101010, 0, 4'd7, C_RWB);
        add("add.fetch", 0, RT, 6'b100000, 0, 4'd0, C_F);
        add("add.dec",   0, RT, 6'b100000, 0, 4'd1, C_D);
        add("add.ex",    0, RT, 6'b100000, 0, 4'd6, rex(3'b010));
        add("add.wb",    0, RT, 6'b100000, 0, 4'd7, C_RWB);
        add("sub.fetch", 0, RT, 6'b100010, 0, 4'd0, C_F);
        add("sub.dec",   0, RT, 6'b100010, 0, 4'd1, C_D);
        add("sub.ex",    0, RT, 6'b100010, 0, 4'd6, rex(3'b110));
        add("sub.wb",    0, RT, 6'b100010, 0, 4'd7, C_RWB);
        add("and.fetch", 0, RT, 6'b100100, 0, 4'd0, C_F);
        add("and.dec",   0, RT, 6'b100100, 0, 4'd1, C_D);
        add("and.ex",    0, RT, 6'b100100, 0, 4'd6, rex(3'b000));
        add("and.wb",    0, RT, 6'b100100, 0, 4'd7, C_RWB);
        add("or.fetch",  0, RT, 6'b100101, 0, 4'd0, C_F);
        add("or.dec",    0, RT, 6'b100101, 0, 4'd1, C_D);
        add("or.ex",     0, RT, 6'b100101, 0, 4'd6, rex(3'b001));
        add("or.wb",     0, RT, 6'b100101, 0, 4'd7, C_RWB);
        add("badfn.fetch", 0, RT, 6'b000111, 0, 4'd0, C_F);
        add("badfn.dec",   0, RT, 6'b000111, 0, 4'd1, C_DI);
        add("badop.fetch", 0, 6'b111111, 6'd0, 0, 4'd0, C_F);
        add("badop.dec",   0, 6'b111111, 6'd0, 0, 4'd1, C_DI);
        add("beq1.fetch", 0, BEQ, 6'd0, 1, 4'd0, C_F);
        add("beq1.dec",   0, BEQ, 6'd0, 1, 4'd1, C_D);
        add("beq1.ex",    0, BEQ, 6'd0, 1, 4'd8, C_BZ1);
        add("beq0.fetch", 0, BEQ, 6'd0, 0, 4'd0, C_F);
        add("beq0.dec",   0, BEQ, 6'd0, 0, 4'd1, C_D);
        add("beq0.ex",    0, BEQ, 6'd0, 0, 4'd8, C_BZ0);
        add("j.fetch",    0, JMP, 6'd0, 1, 4'd0, C_F);
        add("j.dec",      0, JMP, 6'd0, 1, 4'd1, C_D);
        add("j.ex",       0, JMP, 6'd0, 1, 4'd11, C_J);
        add("addi.fetch", 0, ADDI, 6'd0, 0, 4'd0, C_F);
        add("addi.dec",   0, ADDI, 6'd0, 0, 4'd1, C_D);
        add("addi.ex",    0, ADDI, 6'd0, 0, 4'd9, C_AE);
        add("addi.wb",    0, ADDI, 6'd0, 0, 4'd10, C_AWB);
        // reset held three cycles from RTYPEEX: writes gated, instruction abandoned
        add("rst.fetch",  0, RT, 6'b101010, 0, 4'd0, C_F);
        add("rst.dec",    0, RT, 6'b101010, 0, 4'd1, C_D);
        add("rst.in_ex",  1, RT, 6'b101010, 0, 4'd6, rex(3'b111));
        add("rst.hold1",  1, RT, 6'b101010, 0, 4'd0, C_FW);
        add("rst.hold2",  1, RT, 6'b101010, 0, 4'd0, C_FW);
        add("rst.refetch", 0, ADDI, 6'd0, 0, 4'd0, C_F);
        add("rst.addi.dec", 0, ADDI, 6'd0, 0, 4'd1, C_D);
        add("rst.addi.ex",  0, ADDI, 6'd0, 0, 4'd9, C_AE);
        add("rst.addi.wb",  0, ADDI, 6'd0, 0, 4'd10, C_AWB);

        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
            exp_q.push_back({vecs[i].exp_state, vecs[i].exp_ctrl});
            @(negedge clk);
            check(vecs[i].name, obs_a());
            @(posedge clk);
            #1;
        end

        // FETCH_WAIT=2: two back-to-back sw, FETCH lasts 3 cycles with irwrite only in the last
        reset = 1'b1; op = SW; funct = 6'd0; zero = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({4'd0, C_FW});
            exp_q.push_back({4'd0, C_FW});
            exp_q.push_back({4'd0, C_F});
            exp_q.push_back({4'd1, C_D});
            exp_q.push_back({4'd2, C_MA});
            exp_q.push_back({4'd5, C_MWR});
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                check($sformatf("wait2.sw%0d.cyc%0d", k, c), obs_b());
                @(posedge clk);
                #1;
            end
        end

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover: %0d expected entries never compared, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control unit that sequences the shared MIPS datapath: one ALU, one unified instruction/data memory and the register file.
- Moore FSM steps each instruction through fetch/decode/execute/memory/writeback and drives every datapath mux select and write enable.
- Sits between the instruction register (op/funct) and the datapath inside the MIPS top level; clocked from CLOCK_50.

Parameters:
FETCH_WAIT, 0, extra memory wait cycles held in FETCH before the IR/PC are written (0..15).

Ports:
CLOCK_50  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
op  input  6  instr[31:26] from the instruction register.
funct  input  6  instr[5:0] from the instruction register.
zero  input  1  ALU zero flag.
iord  output  1  memory address select: 0=PC, 1=ALUOut.
memwrite  output  1  memory write enable.
irwrite  output  1  instruction register load.
regdst  output  1  register-file write address select: 0=rt, 1=rd.
memtoreg  output  1  register-file write data select: 0=ALUOut, 1=MDR.
regwrite  output  1  register-file write enable.
alusrca  output  1  ALU A select: 0=PC, 1=A.
alusrcb  output  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2.
pcsrc  output  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target.
pcen  output  1  PC load = pcwrite | (branch & zero).
alucontrol  output  3  ALU operation.
instr_done  output  1  one-cycle pulse in the final state of each instruction.
illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported op or funct.
state  output  4  current state, for debug.

Behaviour:
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 return to FETCH on the next cycle with all outputs 0.
- Reset: the next edge with reset=1 sets state=FETCH and wait counter=0. While reset=1, memwrite, irwrite, regwrite, pcen, instr_done and illegal_op are forced 0. Reset mid-instruction abandons it; no further writes occur.
- FETCH:
  - Drives iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - The wait counter increments each cycle; irwrite and pcwrite assert only in the cycle where counter==FETCH_WAIT.
  - That cycle transitions to DECODE and clears the counter.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - lw 100011 or sw 101011 -> MEMADR
  - R-type 000000 -> RTYPEEX
  - beq 000100 -> BEQEX
  - addi 001000 -> ADDIEX
  - j 000010 -> JEX
  - Any other op, or R-type with a funct outside the table below, -> FETCH with illegal_op=1 for that cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1 -> FETCH.
- MEMWR: iord=1, memwrite=1, instr_done=1 -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, instr_done=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1, instr_done=1 -> FETCH.
- Any output not listed for a state is 0.
- ALU decoder (combinational from aluop and funct):
  - aluop 00 -> 010 (add); 01 -> 110 (sub).
  - aluop 10, by funct: 100000 -> 010 add, 100010 -> 110 sub, 100100 -> 000 and, 100101 -> 001 or, 101010 -> 111 slt, any other -> 010.
- Outputs are combinational from the registered state and inputs. No output depends on op/funct except the DECODE/MEMADR branching and alucontrol.
- Cycle counts at FETCH_WAIT=0: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each adds FETCH_WAIT cycles.

Test Plan:
- Reset: hold reset 3 cycles mid-RTYPEEX, then release -> state=0, no regwrite/memwrite/pcen seen; first FETCH asserts irwrite=1, pcen=1, alusrcb=01.
- lw (op=100011), FETCH_WAIT=0 -> states 0,1,2,3,4 across 5 cycles; MEMWB shows regwrite=1, memtoreg=1, regdst=0, and instr_done pulses once.
- R-type: funct=101010 -> RTYPEEX alucontrol=111, RTYPEWB regdst=1 regwrite=1; funct=000111 -> illegal_op pulse in DECODE, then return to FETCH.
- beq: with zero=1 -> pcen=1, pcsrc=01 in BEQEX; with zero=0 -> pcen=0; both take 3 cycles.
- FETCH_WAIT=2 with sw -> FETCH lasts 3 cycles, irwrite only in the 3rd; MEMWR iord=1 memwrite=1; 6 cycles total.
- j then addi back-to-back -> JEX pcsrc=10 pcen=1; ADDIEX alusrcb=10 alucontrol=010; ADDIWB regwrite=1 regdst=0 memtoreg=0.
